rr_arbiter_8: RTL

Eight-way round-robin arbiter that selects one of eight requesters and presents the winner as a registered 3-bit index plus valid. It sits directly upstream of the 3-to-8 decoder: `grant_idx` drives the decoder's `in`, and `grant_valid` drives its `ena`, so the decoder output becomes the one-hot grant vector. A valid/ready handshake with the consumer holds each grant stable until the consumer accepts it.

---
 rtl/rr_arbiter_8.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered winner index
// and valid, held under a valid/ready handshake until the consumer accepts it.
// grant_idx/grant_valid are meant to drive a 3-to-8 decoder's in/ena.
// Optional feature macro: RR_ARB_LOCK_EN adds a 'lock' input that keeps the
// accepted requester at top priority for multi-beat ownership.
module rr_arbiter_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       grant_valid,
    output logic [2:0] grant_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    state_t     state, next_state;
    logic [2:0] idx_q, next_idx;
    logic [2:0] ptr_q, next_ptr;
    logic [2:0] accept_ptr;
    pick_t      idle_pick;
    pick_t      accept_pick;

    // First set bit of r searching upward from base, wrapping 7 -> 0.
    function automatic pick_t rr_pick(input logic [7:0] r, input logic [2:0] base);
        pick_t      res;
        logic [2:0] cand;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            cand = base + 3'(i);
            if (!res.found && r[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    // Pointer value loaded on an accept: advance past the winner unless locked.
`ifdef RR_ARB_LOCK_EN
    assign accept_ptr = lock ? idx_q : idx_q + 3'd1;
`else
    assign accept_ptr = idx_q + 3'd1;
`endif

    // Two candidate arbitrations: from the current pointer (IDLE) and from
    // the post-accept pointer (GRANT with accept), so an accept re-arbitrates
    // in the same edge without a bubble.
    assign idle_pick   = rr_pick(req, ptr_q);
    assign accept_pick = rr_pick(req, accept_ptr);

    // State register: FSM state, held winner index and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx_q <= 3'd0;
            ptr_q <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
            idx_q <= next_idx;
            ptr_q <= next_ptr;
        end
    end

    // Next-state logic: arbitrate from IDLE, hold while unaccepted, re-arbitrate on accept.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        next_state = state;
        next_idx   = idx_q;
        next_ptr   = ptr_q;
        unique case (state)
            IDLE: begin
                if (idle_pick.found) begin
                    next_idx   = idle_pick.idx;
                    next_state = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    next_ptr = accept_ptr;
                    if (accept_pick.found) begin
                        next_idx   = accept_pick.idx;
                        next_state = GRANT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs come straight from flops; no combinational path from req.
    always_comb begin
        grant_valid = (state == GRANT);
        grant_idx   = idx_q;
    end

endmodule
